// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register bank behind the SPI frame decoder
//   Holds six RW config registers (0 = CTRL / irq mask, 1..5 = CFG), a W1C sticky
//   event register (6) and a read-only ID (7). Reads are registered with 1-cycle latency.
//   Ports: clk, rstb (sync, active-low), ena (global hold), reg_addr/wr_data/wr_dv (decoded
//   access), event_i (level events), rd_data (registered read), status (frame status byte),
//   cfg_o (registers 0..5 packed), irq (registered masked interrupt).
module spi_reg_bank #(
    parameter int                ADDR_W   = 3,
    parameter int                REG_W    = 8,
    parameter logic [REG_W-1:0]  ID_VALUE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic [ADDR_W-1:0]    reg_addr,
    input  logic [REG_W-1:0]     wr_data,
    input  logic                 wr_dv,
    input  logic [REG_W-1:0]     event_i,
    output logic [REG_W-1:0]     rd_data,
    output logic [7:0]           status,
    output logic [6*REG_W-1:0]   cfg_o,
    output logic                 irq
);
    logic [5:0][REG_W-1:0] cfg_q, cfg_d;
    logic [REG_W-1:0]      event_q, event_d, rd_q, rd_d;
    logic [3:0]            wr_cnt_q, wr_cnt_d;
    logic                  wr_err_q, wr_err_d, irq_q, irq_d;
    logic                  we;

    assign we = ena & wr_dv;

    always_comb begin
        for (int i = 0; i < 6; i++)
            cfg_d[i] = (we && reg_addr == ADDR_W'(i)) ? wr_data : cfg_q[i];
        // set wins over a same-cycle W1C on the same bit
        event_d  = ((we && reg_addr == ADDR_W'(6)) ? (event_q & ~wr_data) : event_q) | event_i;
        wr_cnt_d = (we && reg_addr != ADDR_W'(7)) ? wr_cnt_q + 4'd1 : wr_cnt_q;
        wr_err_d = wr_err_q | (we && reg_addr == ADDR_W'(7));
        // read samples pre-edge state, so a write shows up on the following read
        rd_d = (reg_addr == ADDR_W'(7)) ? ID_VALUE : event_q;
        for (int i = 0; i < 6; i++)
            if (reg_addr == ADDR_W'(i)) rd_d = cfg_q[i];
        irq_d = |(event_q & cfg_q[0]);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cfg_q    <= '0;
            event_q  <= '0;
            wr_cnt_q <= '0;
            wr_err_q <= 1'b0;
            rd_q     <= '0;
            irq_q    <= 1'b0;
        end else if (ena) begin
            cfg_q    <= cfg_d;
            event_q  <= event_d;
            wr_cnt_q <= wr_cnt_d;
            wr_err_q <= wr_err_d;
            rd_q     <= rd_d;
            irq_q    <= irq_d;
        end
    end

    assign rd_data = rd_q;
    assign irq     = irq_q;
    assign cfg_o   = cfg_q;
    assign status  = {|event_q, wr_err_q, 2'b00, wr_cnt_q};
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed self-checking bench for spi_reg_bank
module tb_spi_reg_bank;
    logic        clk = 1'b0;
    logic        rstb, ena, wr_dv;
    logic [2:0]  reg_addr;
    logic [7:0]  wr_data, event_i, rd_data, status;
    logic [47:0] cfg_o;
    logic        irq;
    int          errors = 0;
    int          checks = 0;

    spi_reg_bank dut (
        .clk(clk), .rstb(rstb), .ena(ena), .reg_addr(reg_addr), .wr_data(wr_data),
        .wr_dv(wr_dv), .event_i(event_i), .rd_data(rd_data), .status(status),
        .cfg_o(cfg_o), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_addr = a;
        wr_data  = d;
        wr_dv    = 1'b1;
        step();
        wr_dv    = 1'b0;
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; wr_dv = 1'b0; reg_addr = '0; wr_data = '0; event_i = '0;
        step(); step();
        check("rst_rd", rd_data, 0);
        check("rst_status", status, 8'h00);
        check("rst_cfg", cfg_o, 0);
        check("rst_irq", irq, 0);
        rstb = 1'b1;

        wr(2, 8'h3C);
        check("w2_cfg", cfg_o[23:16], 8'h3C);
        check("w2_status", status, 8'h01);
        check("w2_rd_old", rd_data, 8'h00);
        step();
        check("w2_rd_new", rd_data, 8'h3C);

        wr(0, 8'h04);
        reg_addr = 6;
        event_i  = 8'h05;
        step();
        event_i  = 8'h00;
        check("ev_status", status, 8'h82);
        check("ev_irq_lag", irq, 0);
        step();
        check("ev_irq", irq, 1);
        check("ev_rd", rd_data, 8'h05);
        wr(6, 8'h04);
        check("w1c_irq_lag", irq, 1);
        step();
        check("w1c_rd", rd_data, 8'h01);
        check("w1c_irq", irq, 0);

        reg_addr = 6; wr_data = 8'h01; wr_dv = 1'b1; event_i = 8'h01;
        step();
        wr_dv = 1'b0; event_i = 8'h00;
        step();
        check("setwins_rd", rd_data, 8'h01);
        check("setwins_status", status, 8'h84);
        wr(6, 8'h01);
        check("clr_status", status, 8'h05);

        wr(7, 8'hFF);
        check("id_status", status, 8'h45);
        step();
        check("id_rd", rd_data, 8'hA5);
        check("id_cfg", cfg_o, 48'h0000_003C_0004);

        for (int i = 0; i < 11; i++) wr(1, 8'h10 + 8'(i));
        check("cnt_wrap", status, 8'h40);
        for (int i = 11; i < 16; i++) wr(1, 8'h10 + 8'(i));
        check("cnt_after", status, 8'h45);
        step();
        check("cfg1_rd", rd_data, 8'h1F);

        ena = 1'b0; wr_dv = 1'b1; reg_addr = 0; wr_data = 8'hFF; event_i = 8'hFF;
        step(); step();
        check("hold_status", status, 8'h45);
        check("hold_cfg", cfg_o, 48'h0000_003C_1F04);
        check("hold_rd", rd_data, 8'h1F);
        check("hold_irq", irq, 0);
        ena = 1'b1; wr_dv = 1'b0; event_i = 8'h00; reg_addr = 6;
        step();
        check("hold_event", rd_data, 8'h00);

        rstb = 1'b0; wr_dv = 1'b1; reg_addr = 0; wr_data = 8'h55; event_i = 8'hFF;
        step();
        wr_dv = 1'b0; event_i = 8'h00; rstb = 1'b1;
        check("rstwin_cfg", cfg_o, 0);
        check("rstwin_status", status, 8'h00);
        check("rstwin_rd", rd_data, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
